// File: rtl/stall_countdown.sv
// stall_countdown: turns the stall detector's countdown request (cd_en/cd_amt)
// into a multi-cycle stall_1 or stall_2 pulse. A one-cycle re-arm guard follows
// each countdown, and a flush aborts the countdown. The block also keeps a
// saturating count of stalled cycles.
//
// Request handshake: cd_en/cd_amt/cd_pipe form a request with no ready signal.
// The request is sampled on a rising edge and accepted only when all of these
// hold: the FSM is in IDLE (cd_busy==0), flush==0, and cd_amt!=0. A request
// that is not accepted is dropped; the detector is expected to re-raise it.
//
// state_dbg encoding: 0 = IDLE, 1 = COUNT, 2 = GUARD.
module stall_countdown #(
    parameter int CNT_W   = 3,
    parameter int MAX_AMT = 7,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cd_en,
    input  logic [CNT_W-1:0]  cd_amt,
    input  logic              cd_pipe,
    input  logic              flush,
    output logic              stall_1,
    output logic              stall_2,
    output logic              cd_busy,
    output logic [CNT_W-1:0]  cd_remaining,
    output logic [PERF_W-1:0] perf_stalls,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_AMT);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               pipe_q;
    logic [CNT_W-1:0]   amt_clamped;
    logic               accept;

    // Clamp the requested amount and decide whether an IDLE request is taken.
    always_comb begin
        amt_clamped = cd_amt;
        if (cd_amt > MAX_C) begin
            amt_clamped = MAX_C;
        end
        accept = (state == IDLE) && cd_en && (cd_amt != '0) && !flush;
    end

    // Countdown FSM with registered stall/busy outputs; flush overrides everything.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            counter <= '0;
            pipe_q  <= 1'b0;
            stall_1 <= 1'b0;
            stall_2 <= 1'b0;
            cd_busy <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            counter <= '0;
            stall_1 <= 1'b0;
            stall_2 <= 1'b0;
            cd_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= COUNT;
                        counter <= amt_clamped;
                        pipe_q  <= cd_pipe;
                        stall_1 <= !cd_pipe;
                        stall_2 <= cd_pipe;
                        cd_busy <= 1'b1;
                    end
                end
                COUNT: begin
                    // The stall pulse ends on the edge that consumes the last
                    // count. The guard cycle then lets the detector re-evaluate
                    // before it can re-arm.
                    if (counter == ONE_C) begin
                        state   <= GUARD;
                        counter <= '0;
                        stall_1 <= 1'b0;
                        stall_2 <= 1'b0;
                    end else begin
                        counter <= counter - ONE_C;
                        stall_1 <= !pipe_q;
                        stall_2 <= pipe_q;
                    end
                    cd_busy <= 1'b1;
                end
                GUARD: begin
                    state   <= IDLE;
                    counter <= '0;
                    stall_1 <= 1'b0;
                    stall_2 <= 1'b0;
                    cd_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    stall_1 <= 1'b0;
                    stall_2 <= 1'b0;
                    cd_busy <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of edges on which either stall output is high.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_stalls <= '0;
        end else if ((stall_1 || stall_2) && (perf_stalls != PERF_MAX)) begin
            perf_stalls <= perf_stalls + PERF_W'(1);
        end
    end

    // The counter is zero outside COUNT, so it is also the remaining-cycles output.
    assign cd_remaining = counter;
    assign state_dbg    = state;

endmodule
